// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM state encoding, HI/LO pair type and op classifiers for the multiply/divide unit.
// No logic of its own; the helper functions are purely combinational.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU opcodes to the multi-cycle class.
package mdu_pkg;

   localparam logic [3:0] NOP   = 4'd0;
   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MFHI  = 4'd5;
   localparam logic [3:0] MFLO  = 4'd6;
   localparam logic [3:0] MTHI  = 4'd7;
   localparam logic [3:0] MTLO  = 4'd8;
   localparam logic [3:0] MADD  = 4'd9;
   localparam logic [3:0] MADDU = 4'd10;
   localparam logic [3:0] MSUB  = 4'd11;
   localparam logic [3:0] MSUBU = 4'd12;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   // Ops that occupy the unit for several cycles and therefore raise busy.
   function automatic logic is_busy_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
`else
      return op inside {MULT, MULTU, DIV, DIVU};
`endif
   endfunction

   // Divides use the longer busy time.
   function automatic logic is_div_op(input logic [3:0] op);
      return op inside {DIV, DIVU};
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: 64-bit {hi,lo} result of a mult/div (or multiply-accumulate) from op, operands and current HI/LO.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the result.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output hilo_t       res
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] q_raw;
   logic [31:0] r_raw;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        sgn;

   // One shared unsigned divider; signed divide works on magnitudes and fixes signs afterwards,
   // which also gives 0x80000000 / -1 = 0x80000000 remainder 0 without overflow.
   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      a_mag  = a[31] ? (~a + 32'd1) : a;
      b_mag  = b[31] ? (~b + 32'd1) : b;
      sgn    = (op == DIV);
      div_a  = sgn ? a_mag : a;
      div_b  = sgn ? b_mag : b;
      q_raw  = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
      r_raw  = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
      quo    = (sgn && (a[31] ^ b[31])) ? (~q_raw + 32'd1) : q_raw;
      rem    = (sgn && a[31]) ? (~r_raw + 32'd1) : r_raw;
      // Default keeps HI/LO, which is exactly what a divide by zero must commit.
      res    = {hi, lo};
      case (op)
         MULT:  res = prod_s;
         MULTU: res = prod_u;
         DIV:   if (b != 32'd0) res = {rem, quo};
         DIVU:  if (b != 32'd0) res = {rem, quo};
`ifdef MDU_MADD_EN
         MADD:  res = {hi, lo} + prod_s;
         MADDU: res = {hi, lo} + prod_u;
         MSUB:  res = {hi, lo} - prod_s;
         MSUBU: res = {hi, lo} - prod_u;
`endif
         default: res = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mdu_core.sv
// mdu_core: E-stage multiply/divide unit owning HI/LO, with busy and D-stage stall request (MDU_MADD_EN enables MADD/MSUB family).
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles after the start cycle; HI/LO readable the cycle after busy drops; MTHI/MTLO take one edge.
// Backpressure: stallMD holds a D-stage MD instruction while busy or while a multi-cycle op starts; starts while busy are dropped.
module mdu_core
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        mdD,
   output logic        busy,
   output logic        stallMD,
   output logic [31:0] mdOut
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   hilo_t       pend, pend_nxt;
   hilo_t       hilo, hilo_nxt;
   hilo_t       arith_res;

   mdu_arith u_arith (
      .op  (mdOp),
      .a   (A),
      .b   (B),
      .hi  (hilo.hi),
      .lo  (hilo.lo),
      .res (arith_res)
   );

   assign busy    = (state == RUN);
   assign stallMD = mdD & (busy | (start & is_busy_op(mdOp)));

   // Register state, counter, pending result and HI/LO; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= '0;
         hilo  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pend  <= pend_nxt;
         hilo  <= hilo_nxt;
      end
   end

   // Next-state: the result is captured at start and only copied into HI/LO on the final busy cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pend;
      hilo_nxt  = hilo;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_busy_op(mdOp)) begin
                  pend_nxt  = arith_res;
                  cnt_nxt   = is_div_op(mdOp) ? DIV_N : MULT_N;
                  state_nxt = RUN;
               end else if (mdOp == MTHI) begin
                  hilo_nxt.hi = A;
               end else if (mdOp == MTLO) begin
                  hilo_nxt.lo = A;
               end
            end
         end
         RUN: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               hilo_nxt  = pend;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Move-from read port straight off the HI/LO registers.
   always_comb begin
      mdOut = 32'd0;
      if (mdOp == MFHI) mdOut = hilo.hi;
      else if (mdOp == MFLO) mdOut = hilo.lo;
   end

endmodule

// File: tb/tb_mdu_core.sv
module tb_mdu_core;
   import mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  mdOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        mdD;
   logic        busy;
   logic        stallMD;
   logic [31:0] mdOut;

   mdu_core #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdOp    (mdOp),
      .A       (A),
      .B       (B),
      .mdD     (mdD),
      .busy    (busy),
      .stallMD (stallMD),
      .mdOut   (mdOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_checks = 0;
   int n_overlap = 0;

   // Reference state: architectural HI/LO, cycles of busy left, result waiting to land.
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   int          m_left;

   logic [31:0] last_out;
   logic        last_stall;

   // Protocol monitor: the hazard unit must never start a command while busy.
   always @(posedge clk) if (reset && start && busy) n_overlap++;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic ref_busy_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   function automatic int ref_cycles(input logic [3:0] op);
      return (op == DIV || op == DIVU) ? DC : MC;
   endfunction

   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
      longint sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = {hi, lo};
      case (op)
         MULT:  r = sa * sb;
         MULTU: r = {32'd0, a} * {32'd0, b};
         DIV:   if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         DIVU:  if (b != 0) r = {a % b, a / b};
`ifdef MDU_MADD_EN
         MADD:  r = {hi, lo} + 64'(sa * sb);
         MADDU: r = {hi, lo} + {32'd0, a} * {32'd0, b};
         MSUB:  r = {hi, lo} - 64'(sa * sb);
         MSUBU: r = {hi, lo} - {32'd0, a} * {32'd0, b};
`endif
         default: r = {hi, lo};
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
   endtask

   task automatic model_step(input logic st, input logic [3:0] op, input logic [31:0] a, b);
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) {m_hi, m_lo} = m_pend;
      end else if (st) begin
         if (ref_busy_op(op)) begin
            m_pend = ref_result(op, a, b, m_hi, m_lo);
            m_left = ref_cycles(op);
         end else if (op == MTHI) m_hi = a;
         else if (op == MTLO) m_lo = a;
      end
   endtask

   // One clock cycle: drive, check combinational outputs against the model, advance.
   task automatic cycle(input logic st, input logic [3:0] op, input logic [31:0] a, b, input logic d);
      logic [31:0] exp_out;
      start = st; mdOp = op; A = a; B = b; mdD = d;
      #1;
      exp_out = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
      check("busy", 32'(busy), 32'(m_left != 0));
      check("stallMD", 32'(stallMD), 32'(d && (m_left != 0 || (st && ref_busy_op(op)))));
      check("mdOut", mdOut, exp_out);
      last_out   = mdOut;
      last_stall = stallMD;
      @(posedge clk);
      model_step(st, op, a, b);
      #1;
   endtask

   task automatic wait_idle(output int nb);
      nb = 0;
      for (int k = 0; k < 20 && busy; k++) begin
         cycle(1'b0, NOP, 32'd0, 32'd0, 1'b0);
         nb++;
      end
   endtask

   initial begin
      int nb;
      vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult_neg"};
      vecs[1] = '{DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DC, "divu_7_2"};
      vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_m7_2"};
      vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, "div_ovf"};
      vecs[4] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC, "multu_max"};
      vecs[5] = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC, "div_7_m2"};
      vecs[6] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, "mult_min"};
      vecs[7] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DC, "divu_big"};

      // Reset state; stallMD stays combinational even in reset.
      reset = 1'b0; start = 1'b0; mdOp = NOP; A = 0; B = 0; mdD = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      mdOp = MFHI; #1; check("rst_hi", mdOut, 32'd0);
      mdOp = MFLO; #1; check("rst_lo", mdOut, 32'd0);
      start = 1'b1; mdOp = MULT; mdD = 1'b1; #1;
      check("rst_stall_comb", 32'(stallMD), 32'd1);
      start = 1'b0; mdOp = NOP; mdD = 1'b0;
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // Directed table of operations with known results.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         wait_idle(nb);
         check({vecs[i].name, "_busycyc"}, 32'(nb), 32'(vecs[i].cyc));
         cycle(1'b0, MFHI, 32'd0, 32'd0, 1'b0);
         check({vecs[i].name, "_hi"}, last_out, vecs[i].hi);
         cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);
         check({vecs[i].name, "_lo"}, last_out, vecs[i].lo);
      end

      // Divide by zero leaves HI/LO untouched after a full divide time.
      cycle(1'b1, MTHI, 32'h11, 32'd0, 1'b0);
      cycle(1'b1, MTLO, 32'h22, 32'd0, 1'b0);
      cycle(1'b1, DIV, 32'd5, 32'd0, 1'b0);
      wait_idle(nb);
      check("divz_busycyc", 32'(nb), 32'(DC));
      cycle(1'b0, MFHI, 32'd0, 32'd0, 1'b0);
      check("divz_hi", last_out, 32'h11);
      cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);
      check("divz_lo", last_out, 32'h22);

      // Stall window T..T+5 with a dropped start at T+2.
      cycle(1'b1, MULT, 32'd3, 32'd4, 1'b1);
      check("stall_T0", 32'(last_stall), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) cycle(1'b1, MULT, 32'd9, 32'd9, 1'b1);
         else cycle(1'b0, NOP, 32'd0, 32'd0, 1'b1);
         check($sformatf("stall_T%0d", k), 32'(last_stall), (k <= 5) ? 32'd1 : 32'd0);
      end
      check("overlap_seen", 32'(n_overlap), 32'd1);
      cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);
      check("stall_lo", last_out, 32'd12);
      cycle(1'b0, MFHI, 32'd0, 32'd0, 1'b0);
      check("stall_hi", last_out, 32'd0);

      // Optional accumulate ops: real work when enabled, silent no-op otherwise.
      cycle(1'b1, MTHI, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, MTLO, 32'd10, 32'd0, 1'b0);
      cycle(1'b1, MADD, 32'd2, 32'd3, 1'b1);
`ifdef MDU_MADD_EN
      check("madd_stall", 32'(last_stall), 32'd1);
`else
      check("madd_stall", 32'(last_stall), 32'd0);
`endif
      wait_idle(nb);
      cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
      check("madd_lo", last_out, 32'd16);
`else
      check("madd_lo", last_out, 32'd10);
`endif

      // Reset in the third busy cycle of a divide.
      cycle(1'b1, MTHI, 32'hAAAA5555, 32'd0, 1'b0);
      cycle(1'b1, MTLO, 32'h5555AAAA, 32'd0, 1'b0);
      cycle(1'b1, DIV, 32'd100, 32'd7, 1'b0);
      cycle(1'b0, NOP, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, NOP, 32'd0, 32'd0, 1'b0);
      reset = 1'b0; start = 1'b0; mdOp = MFHI;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_hi", mdOut, 32'd0);
      mdOp = MFLO; #1;
      check("midrst_lo", mdOut, 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      cycle(1'b1, MTLO, 32'd5, 32'd0, 1'b0);
      cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);
      check("mtlo_after_rst", last_out, 32'd5);

      // Randomized legal traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         logic        st;
         op = 4'($urandom_range(0, 12));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: b = $urandom_range(1, 9);
            default: ;
         endcase
         st = (m_left == 0) && ($urandom_range(0, 3) != 0);
         cycle(st, op, a, b, 1'($urandom_range(0, 1)));
      end
      wait_idle(nb);
      cycle(1'b0, MFHI, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, MFLO, 32'd0, 32'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
